serial_nibble_framer: RTL
=========================

# serial_nibble_framer

Upstream stage of the 4-bit pattern detector. Collects a serial, MSB-first bit stream into 4-bit nibbles, aligned by a frame-sync strobe. Presents each completed nibble on `x[3:0]` through a one-entry valid/ready output buffer, so the detector and any registered consumer behind it see stable nibbles. Also reports buffer overflow and a running count of delivered nibbles.

## Interface
- No parameters; nibble width is fixed at 4 bits and the count width at 8 bits.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is sampled only on cycles where this is 1.
- `sync`  in  1  qualified by `sin_valid`; marks the current `sin` bit as the MSB (bit 3) of a new nibble.
- `x`  out  4  buffered nibble, MSB = first received bit; feeds the detector input.
- `out_valid`  out  1  `x` holds an undelivered nibble.
- `out_ready`  in  1  consumer accepts `x` on a cycle where `out_valid` and `out_ready` are both 1.
- `ovf`  out  1  sticky; a completed nibble was dropped because the buffer was occupied.
- `nib_cnt`  out  8  number of nibbles loaded into the buffer, modulo 256.

## Operation
- **State machine** with two states: `IDLE` and `SHIFT`.
  - Reset enters `IDLE`. The bit counter `bcnt` (2 bits) is 0.
  - `IDLE`: bits with `sin_valid=1, sync=0` are ignored. On `sin_valid=1, sync=1`:
    - shift register bit 3 ← `sin`;
    - `bcnt` ← 1;
    - go to `SHIFT`.
  - `SHIFT`, on `sin_valid=1, sync=0`: shift `sin` into the next lower bit position and increment `bcnt`.
    - On the 4th bit (`bcnt` == 3 before the edge) the nibble is complete.
    - `bcnt` wraps to 0 and the FSM stays in `SHIFT`. Framing is continuous: the next 4 valid bits form the next nibble with no new `sync` required.
  - `SHIFT`, on `sin_valid=1, sync=1`: discard any partial nibble. The current bit becomes bit 3 of a new nibble and `bcnt` ← 1.
    - A `sync` arriving on what would be the 4th bit does not complete a nibble. That bit restarts framing.
  - `sin_valid=0`: shift register, `bcnt` and state all hold.
- **Nibble completion**, resolved on the same edge:
  - Buffer empty, or buffer draining this cycle (`out_valid & out_ready`): load the new nibble into `x`, set or keep `out_valid=1`, and increment `nib_cnt`.
  - Buffer full and not draining: drop the nibble. `x`, `out_valid` and `nib_cnt` are unchanged, and `ovf` ← 1.
- **Drain without completion**: on `out_valid & out_ready`, `out_valid` ← 0 and `x` holds its last value.
- `ovf` clears only on `rst`.
- `nib_cnt` wraps from 255 to 0 with no flag.
- The block never stalls input; there is no back-pressure on `sin`.

## Timing
- **Reset values**: `x=4'b0000`, `out_valid=0`, `ovf=0`, `nib_cnt=8'd0`, state `IDLE`, `bcnt=0`, shift register 0. `rst` overrides every other input on the same edge.
- **Latency**: when the 4th bit is sampled at edge N, `x`/`out_valid` are updated immediately after edge N. This is one cycle from the last bit to a valid output.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- **Minimum spacing**: with `sin_valid` held high, nibbles complete every 4 cycles. A consumer holding `out_ready=1` never causes `ovf`.
- **Back-to-back handoff**: a drain and a load on the same edge gives `out_valid` continuously 1 with the new `x`.
- **Reset mid-nibble**: partial bits are lost, any buffered nibble is lost, and `ovf`/`nib_cnt` clear. Bits after reset are ignored until the next `sync`.

## Test plan
- **Reset and first nibble**: assert `rst` for 2 cycles, then `sin_valid=1`, `out_ready=1`, bits 1,0,1,1 with `sync` on the first bit.
  - After reset: outputs are 0.
  - Required: `x=4'b1011`, `out_valid=1` the cycle after the 4th bit, `nib_cnt=1`.
- **Continuous stream**: after one `sync`, bits 0011 0110 1001 with `out_ready=1`.
  - Required: `x` = 3, 6, 9 at 4-cycle spacing, `nib_cnt=3`, `ovf=0`.
- **Gapped input**: same 4 bits as scenario 1 with `sin_valid=0` idle cycles inserted between bits.
  - Required: identical `x=4'b1011`; completion edge follows the 4th valid bit.
- **Resync mid-nibble**: `sync` with bit 1, then bits 1,1, then `sync` with bit 0, then 1,1,1.
  - Required: the first partial nibble is discarded and `x=4'b0111`.
- **Overflow**: `out_ready=0`, deliver two full nibbles 1010 then 0110.
  - Required: `x=4'b1010`, `out_valid=1`, `ovf=1`, `nib_cnt=1`.
  - Then pulse `out_ready`: `out_valid=0`, `ovf` stays 1.
- **Simultaneous drain and load**: `out_ready` rises on the exact edge the next nibble completes.
  - Required: `out_valid` never drops and `x` updates to the new nibble. Repeat 256 nibbles to check `nib_cnt` wraps to 0.

Source files
------------

// File: rtl/serial_nibble_framer.sv
// rtl/serial_nibble_framer.sv - serial MSB-first bit stream framed into buffered 4-bit nibbles
// One-entry output buffer with sticky overflow and a modulo-256 delivered-nibble count.
module serial_nibble_framer (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sync,
  output logic [3:0] x,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  output logic [7:0] nib_cnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [3:0]  sr_q, sr_d;
  logic [3:0]  x_q, x_d;
  logic        out_valid_q, out_valid_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  nib_cnt_q, nib_cnt_d;
  logic        complete;
  logic        drain;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    sr_d        = sr_q;
    x_d         = x_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    nib_cnt_d   = nib_cnt_q;
    complete    = 1'b0;
    drain       = out_valid_q & out_ready;

    if (sin_valid) begin
      if (sync) begin
        // sync always restarts framing, even on what would be the 4th bit
        sr_d    = {sin, 3'b000};
        bcnt_d  = 2'd1;
        state_d = SHIFT;
      end else if (state_q == SHIFT) begin
        // bit position counts down from 3 as bcnt counts up, i.e. position = ~bcnt
        sr_d[~bcnt_q] = sin;
        bcnt_d        = bcnt_q + 2'd1;
        complete      = (bcnt_q == 2'd3);
      end
    end

    if (drain) begin
      out_valid_d = 1'b0;
    end

    if (complete) begin
      if (!out_valid_q || drain) begin
        x_d         = sr_d;
        out_valid_d = 1'b1;
        nib_cnt_d   = nib_cnt_q + 8'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= 2'd0;
      sr_q        <= 4'd0;
      x_q         <= 4'd0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      nib_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sr_q        <= sr_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      nib_cnt_q   <= nib_cnt_d;
    end
  end

  assign x         = x_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign nib_cnt   = nib_cnt_q;

endmodule
